router_reg_multi: RTL and testbench

Parametrised datapath register stage for the N-port packet router. It sits between the input port and the router FSM and the destination FIFOs. It latches the header, forwards payload and parity to the FIFO write bus, and buffers bytes while the FIFO is full in a HOLD_DEPTH-deep hold buffer instead of a single holding register. It computes running XOR parity and reports a per-packet sticky parity error.

---
 rtl/router_reg_multi.sv | 178 +++++++++++++++++
 tb/tb_router_reg_multi.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/router_reg_multi.sv
// Router datapath register stage: header latch, FIFO write bus, HOLD_DEPTH-deep hold buffer
// and running XOR parity. Define LEN_CHECK_EN to build the payload length checker.
module router_reg_multi #(
  parameter int unsigned DW         = 8,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned HOLD_DEPTH = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          pkt_valid,
  input  logic [DW-1:0] data_in,
  input  logic          fifo_full,
  input  logic          detect_add,
  input  logic          lfd_state,
  input  logic          ld_state,
  input  logic          laf_state,
  input  logic          full_state,
  input  logic          rst_int_reg,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          hold_empty,
  output logic          hold_full,
  output logic          low_packet_valid,
  output logic          parity_done,
  output logic          err,
  output logic          len_err
);

  localparam int unsigned PW = $clog2(HOLD_DEPTH);
  localparam int unsigned CW = $clog2(HOLD_DEPTH + 1);

  logic [DW-1:0] hold_mem [HOLD_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] header_q, header_d;
  logic [DW-1:0] int_par_q, int_par_d, ext_par_q, ext_par_d;
  logic [DW-1:0] dout_d;
  logic          dout_valid_d, lpv_d, pdone_d, err_d;
  logic          chk_q, chk_d;

  logic ld_active, direct, push, drop, pop, accept, par_accept, addr_ok;

  // full_state is a hold-only state, so it masks any datapath action
  assign ld_active  = ld_state & ~full_state;
  assign direct     = ld_active & ~fifo_full & hold_empty;
  assign push       = ld_active & ~direct & ~hold_full;
  assign drop       = ld_active & ~direct & hold_full;
  assign pop        = laf_state & ~full_state & ~fifo_full & ~hold_empty;
  assign accept     = direct | push;
  assign par_accept = accept & ~pkt_valid & ~parity_done;
  assign addr_ok    = 32'(data_in[ADDR_W-1:0]) < NUM_PORTS;

  always_comb begin
    header_d     = header_q;
    int_par_d    = int_par_q;
    ext_par_d    = ext_par_q;
    dout_d       = dout;
    dout_valid_d = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    lpv_d        = low_packet_valid;
    pdone_d      = parity_done;
    err_d        = err;
    chk_d        = 1'b0;

    if (lfd_state) begin
      dout_d       = header_q;
      dout_valid_d = 1'b1;
      int_par_d    = int_par_q ^ header_q;
    end
    if (direct) begin
      dout_d       = data_in;
      dout_valid_d = 1'b1;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (drop) err_d = 1'b1;
    if (accept && pkt_valid) int_par_d = int_par_d ^ data_in;
    if (par_accept) begin
      ext_par_d = data_in;
      pdone_d   = 1'b1;
      chk_d     = 1'b1;
    end
    if (ld_active && !pkt_valid) lpv_d = 1'b1;
    // Compare one edge after the parity byte lands so ext_par_q is settled
    if (chk_q && (int_par_q != ext_par_q)) err_d = 1'b1;
    if (pop) begin
      dout_d       = hold_mem[rd_ptr_q];
      dout_valid_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    if (rst_int_reg) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      lpv_d    = 1'b0;
      if (pop) begin
        dout_d       = dout;
        dout_valid_d = 1'b0;
      end
    end
    if (detect_add) begin
      if (pkt_valid && addr_ok) header_d = data_in;
      int_par_d = '0;
      ext_par_d = '0;
      pdone_d   = 1'b0;
      err_d     = 1'b0;
      lpv_d     = 1'b0;
      chk_d     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header_q         <= '0;
      int_par_q        <= '0;
      ext_par_q        <= '0;
      dout             <= '0;
      dout_valid       <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      cnt_q            <= '0;
      hold_empty       <= 1'b1;
      hold_full        <= 1'b0;
      low_packet_valid <= 1'b0;
      parity_done      <= 1'b0;
      err              <= 1'b0;
      chk_q            <= 1'b0;
    end else begin
      header_q         <= header_d;
      int_par_q        <= int_par_d;
      ext_par_q        <= ext_par_d;
      dout             <= dout_d;
      dout_valid       <= dout_valid_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      cnt_q            <= cnt_d;
      hold_empty       <= (cnt_d == '0);
      hold_full        <= (cnt_d == CW'(HOLD_DEPTH));
      low_packet_valid <= lpv_d;
      parity_done      <= pdone_d;
      err              <= err_d;
      chk_q            <= chk_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid
  always_ff @(posedge clock) begin
    if (push) hold_mem[wr_ptr_q] <= data_in;
  end

`ifdef LEN_CHECK_EN
  localparam int unsigned LW = DW - ADDR_W;

  logic [LW-1:0] len_cnt_q;
  logic          len_err_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      len_cnt_q <= '0;
      len_err_q <= 1'b0;
    end else if (detect_add) begin
      len_cnt_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (accept && pkt_valid && !(&len_cnt_q)) len_cnt_q <= len_cnt_q + 1'b1;
      if (par_accept && (len_cnt_q != header_q[DW-1:ADDR_W])) len_err_q <= 1'b1;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg_multi.sv
// Directed self-checking bench for router_reg_multi (default parameters).
module tb_router_reg_multi;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg;
  logic [7:0] dout;
  logic       dout_valid, hold_empty, hold_full, low_packet_valid, parity_done, err, len_err;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] SIdle = 5'b00000;
  localparam logic [4:0] SDa   = 5'b10000;
  localparam logic [4:0] SLfd  = 5'b01000;
  localparam logic [4:0] SLd   = 5'b00100;
  localparam logic [4:0] SLaf  = 5'b00010;

  router_reg_multi #(
    .DW(8), .ADDR_W(2), .NUM_PORTS(3), .HOLD_DEPTH(4)
  ) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .dout_valid(dout_valid),
    .hold_empty(hold_empty), .hold_full(hold_full), .low_packet_valid(low_packet_valid),
    .parity_done(parity_done), .err(err), .len_err(len_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 ns after the active edge
  task automatic cyc(input logic [4:0] s, input logic pv, input logic ff, input logic [7:0] d);
    {detect_add, lfd_state, ld_state, laf_state, full_state} = s;
    pkt_valid = pv;
    fifo_full = ff;
    data_in   = d;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v);
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(v));
    if (v) chk({tag, ".dout"}, 32'(dout), 32'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; rst_int_reg = 1'b0;
    {detect_add, lfd_state, ld_state, laf_state, full_state} = SIdle;
    pkt_valid = 1'b0; fifo_full = 1'b0; data_in = 8'h00;
    #12;
    chk("rst.dout", 32'(dout), 32'h0);
    chk("rst.dout_valid", 32'(dout_valid), 32'h0);
    chk("rst.hold_empty", 32'(hold_empty), 32'h1);
    chk("rst.hold_full", 32'(hold_full), 32'h0);
    chk("rst.lpv", 32'(low_packet_valid), 32'h0);
    chk("rst.parity_done", 32'(parity_done), 32'h0);
    chk("rst.err", 32'(err), 32'h0);
    chk("rst.len_err", 32'(len_err), 32'h0);
    resetn = 1'b1;
    @(negedge clock);

    // Scenario 1: good packet, header 0x0D, payload 11 22 33, parity 0x0D
    cyc(SDa, 1'b1, 1'b0, 8'h0D);  chk("s1.hdr_nowrite", 32'(dout_valid), 32'h0);
    cyc(SLfd, 1'b1, 1'b0, 8'h00); chk_out("s1.hdr", 8'h0D, 1'b1);
    cyc(SLd, 1'b1, 1'b0, 8'h11);  chk_out("s1.p0", 8'h11, 1'b1);
    cyc(SLd, 1'b1, 1'b0, 8'h22);  chk_out("s1.p1", 8'h22, 1'b1);
    cyc(SLd, 1'b1, 1'b0, 8'h33);  chk_out("s1.p2", 8'h33, 1'b1);
    chk("s1.lpv_before", 32'(low_packet_valid), 32'h0);
    cyc(SLd, 1'b0, 1'b0, 8'h0D);  chk_out("s1.par", 8'h0D, 1'b1);
    chk("s1.parity_done", 32'(parity_done), 32'h1);
    chk("s1.lpv", 32'(low_packet_valid), 32'h1);
    cyc(SIdle, 1'b0, 1'b0, 8'h00);
    chk("s1.err", 32'(err), 32'h0);
    chk("s1.len_err", 32'(len_err), 32'h0);
    chk("s1.idle_nowrite", 32'(dout_valid), 32'h0);

    // Scenario 2: bad parity byte 0x00
    cyc(SDa, 1'b1, 1'b0, 8'h0D);
    chk("s2.clear_pdone", 32'(parity_done), 32'h0);
    cyc(SLfd, 1'b1, 1'b0, 8'h00);
    cyc(SLd, 1'b1, 1'b0, 8'h11);
    cyc(SLd, 1'b1, 1'b0, 8'h22);
    cyc(SLd, 1'b1, 1'b0, 8'h33);
    cyc(SLd, 1'b0, 1'b0, 8'h00);
    chk("s2.parity_done", 32'(parity_done), 32'h1);
    chk("s2.err_not_yet", 32'(err), 32'h0);
    cyc(SIdle, 1'b0, 1'b0, 8'h00); chk("s2.err_set", 32'(err), 32'h1);
    cyc(SIdle, 1'b0, 1'b0, 8'h00); chk("s2.err_hold", 32'(err), 32'h1);
    rst_int_reg = 1'b1;
    cyc(SIdle, 1'b0, 1'b0, 8'h00);
    rst_int_reg = 1'b0;
    chk("s2.rst_int_lpv", 32'(low_packet_valid), 32'h0);
    chk("s2.err_after_rst_int", 32'(err), 32'h1);
    cyc(SDa, 1'b1, 1'b0, 8'h0D);
    chk("s2.err_clear", 32'(err), 32'h0);

    // Scenario 3: 0x22/0x33 buffered while FIFO full, drained in laf_state
    cyc(SLfd, 1'b1, 1'b0, 8'h00); chk_out("s3.hdr", 8'h0D, 1'b1);
    cyc(SLd, 1'b1, 1'b0, 8'h11);  chk_out("s3.p0", 8'h11, 1'b1);
    cyc(SLd, 1'b1, 1'b1, 8'h22);
    chk("s3.buf0_nowrite", 32'(dout_valid), 32'h0);
    chk("s3.hold_empty0", 32'(hold_empty), 32'h0);
    cyc(SLd, 1'b1, 1'b1, 8'h33);
    chk("s3.buf1_nowrite", 32'(dout_valid), 32'h0);
    chk("s3.hold_full", 32'(hold_full), 32'h0);
    cyc(SLaf, 1'b1, 1'b0, 8'h00); chk_out("s3.pop0", 8'h22, 1'b1);
    chk("s3.hold_empty1", 32'(hold_empty), 32'h0);
    cyc(SLaf, 1'b1, 1'b0, 8'h00); chk_out("s3.pop1", 8'h33, 1'b1);
    chk("s3.hold_empty2", 32'(hold_empty), 32'h1);
    cyc(SLaf, 1'b1, 1'b0, 8'h00); chk("s3.pop_empty", 32'(dout_valid), 32'h0);
    cyc(SLd, 1'b0, 1'b0, 8'h0D);  chk_out("s3.par", 8'h0D, 1'b1);
    cyc(SIdle, 1'b0, 1'b0, 8'h00); chk("s3.err", 32'(err), 32'h0);

    // Scenario 4: overflow of the 4-entry buffer, then flush coinciding with a pop
    cyc(SDa, 1'b1, 1'b0, 8'h0D);
    cyc(SLfd, 1'b1, 1'b0, 8'h00);
    cyc(SLd, 1'b1, 1'b1, 8'h01);
    cyc(SLd, 1'b1, 1'b1, 8'h02);
    cyc(SLd, 1'b1, 1'b1, 8'h03);
    chk("s4.not_full3", 32'(hold_full), 32'h0);
    cyc(SLd, 1'b1, 1'b1, 8'h04);
    chk("s4.full4", 32'(hold_full), 32'h1);
    chk("s4.err_before_drop", 32'(err), 32'h0);
    cyc(SLd, 1'b1, 1'b1, 8'h05);
    chk("s4.drop_err", 32'(err), 32'h1);
    chk("s4.drop_nowrite", 32'(dout_valid), 32'h0);
    rst_int_reg = 1'b1;
    cyc(SLaf, 1'b1, 1'b0, 8'h00);
    rst_int_reg = 1'b0;
    chk("s4.flush_nowrite", 32'(dout_valid), 32'h0);
    chk("s4.flush_empty", 32'(hold_empty), 32'h1);
    chk("s4.flush_notfull", 32'(hold_full), 32'h0);

    // Scenario 5: invalid address keeps header; async reset mid-payload
    cyc(SDa, 1'b1, 1'b0, 8'h03);
    chk("s5.err_clear", 32'(err), 32'h0);
    cyc(SLfd, 1'b1, 1'b0, 8'h00); chk_out("s5.hdr_kept", 8'h0D, 1'b1);
    cyc(SLd, 1'b1, 1'b1, 8'h44);
    chk("s5.buffered", 32'(hold_empty), 32'h0);
    cyc(SLd, 1'b0, 1'b1, 8'h55);
    chk("s5.lpv", 32'(low_packet_valid), 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    chk("s5.arst_dout", 32'(dout), 32'h0);
    chk("s5.arst_hold_empty", 32'(hold_empty), 32'h1);
    chk("s5.arst_lpv", 32'(low_packet_valid), 32'h0);
    chk("s5.arst_pdone", 32'(parity_done), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    cyc(SDa, 1'b1, 1'b0, 8'h07);
    cyc(SLfd, 1'b1, 1'b0, 8'h00); chk_out("s5.hdr_reset", 8'h00, 1'b1);

    // Scenario 6: short packet (two payload bytes against length 3)
    cyc(SDa, 1'b1, 1'b0, 8'h0D);
    cyc(SLfd, 1'b1, 1'b0, 8'h00);
    cyc(SLd, 1'b1, 1'b0, 8'hAA);
    cyc(SLd, 1'b1, 1'b0, 8'hBB);
    cyc(SLd, 1'b0, 1'b0, 8'h0D);
`ifdef LEN_CHECK_EN
    chk("s6.len_err_short", 32'(len_err), 32'h1);
`else
    chk("s6.len_err_tied", 32'(len_err), 32'h0);
`endif
    cyc(SIdle, 1'b0, 1'b0, 8'h00);
    chk("s6.err_short", 32'(err), 32'h1);
    cyc(SDa, 1'b1, 1'b0, 8'h0D);
    chk("s6.len_err_clear", 32'(len_err), 32'h0);
    cyc(SLfd, 1'b1, 1'b0, 8'h00);
    cyc(SLd, 1'b1, 1'b0, 8'hAA);
    cyc(SLd, 1'b1, 1'b0, 8'hBB);
    cyc(SLd, 1'b1, 1'b0, 8'hCC);
    cyc(SLd, 1'b0, 1'b0, 8'h0D);
    chk("s6.len_ok", 32'(len_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
